// File: rtl/key_pkg.sv
// Shared types and the keypad map for the key controller.
package key_pkg;

    typedef enum logic [1:0] {SCAN, DECODE, HOLD} keystate_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } onehot_t;

    // Entry {row,col}: row 0 = 1 2 3 A, row 1 = 4 5 6 B, row 2 = 7 8 9 C, row 3 = E 0 F D
    localparam logic [15:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    function automatic onehot_t onehot_index(input logic [3:0] v);
        onehot_t r;
        r = '0;
        case (v)
            4'b0001: r = '{valid: 1'b1, idx: 2'd0};
            4'b0010: r = '{valid: 1'b1, idx: 2'd1};
            4'b0100: r = '{valid: 1'b1, idx: 2'd2};
            4'b1000: r = '{valid: 1'b1, idx: 2'd3};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_n.sv
// N-stage flip-flop synchronizer for asynchronous inputs, reset to 0.
module sync_n #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [STAGES-1:0][W-1:0] vld_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[STAGES-2:0], d};
    end

    assign q = vld_pipe[STAGES-1];
endmodule

// File: rtl/key_ctrl.sv
// Keypad controller: syncs columns, decodes scanner presses, holds the row until
// the key has stayed released for RELEASE_CYCLES, and keeps a two-digit history.
module key_ctrl
    import key_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int RELEASE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] colsRaw,
    input  logic [3:0] scanRows,
    input  logic       newNum,
    output logic [3:0] colsSync,
    output logic       scanHold,
    output logic [3:0] rows,
    output logic [3:0] key,
    output logic       keyValid,
    output logic       keyErr,
    output logic [3:0] digit1,
    output logic [3:0] digit0
);
    localparam int CW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(RELEASE_CYCLES - 1);

    keystate_t     state;
    logic [3:0]    capRow, capCol;
    logic [CW-1:0] relCnt;
    logic          capHit, released;
    logic [3:0]    nxtRow, nxtCol;
    onehot_t       rowIdx, colIdx, holdRow;

    sync_n #(.W(4), .STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (colsRaw),
        .q    (colsSync)
    );

    // A press pulse in the same cycle as a capture decodes the fresh capture.
    assign capHit   = (scanRows != 4'd0) && (colsSync != 4'd0);
    assign nxtRow   = capHit ? scanRows : capRow;
    assign nxtCol   = capHit ? colsSync : capCol;
    assign rowIdx   = onehot_index(nxtRow);
    assign colIdx   = onehot_index(nxtCol);
    assign holdRow  = onehot_index(capRow);
    assign released = !holdRow.valid || ((colsSync & capCol) == 4'd0);

    always_comb begin
        rows = 4'd0;
        case (state)
            SCAN:    rows = scanRows;
            HOLD:    rows = holdRow.valid ? capRow : 4'd0;
            default: rows = 4'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SCAN;
            capRow   <= '0;
            capCol   <= '0;
            relCnt   <= '0;
            scanHold <= 1'b0;
            key      <= '0;
            keyValid <= 1'b0;
            keyErr   <= 1'b0;
            digit1   <= '0;
            digit0   <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (capHit) begin
                        capRow <= scanRows;
                        capCol <= colsSync;
                    end
                    if (newNum) begin
                        state    <= DECODE;
                        scanHold <= 1'b1;
                        if (rowIdx.valid && colIdx.valid) begin
                            keyValid <= 1'b1;
                            key      <= KEY_MAP[{rowIdx.idx, colIdx.idx}];
                        end else begin
                            keyErr <= 1'b1;
                        end
                    end
                end
                DECODE: begin
                    keyValid <= 1'b0;
                    keyErr   <= 1'b0;
                    if (keyValid) begin
                        digit1 <= digit0;
                        digit0 <= key;
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    // Any pressed sample restarts the release interval.
                    if (!released) begin
                        relCnt <= '0;
                    end else if (relCnt == LAST) begin
                        relCnt   <= '0;
                        capRow   <= '0;
                        capCol   <= '0;
                        scanHold <= 1'b0;
                        state    <= SCAN;
                    end else begin
                        relCnt <= relCnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_key_ctrl.sv
// Directed bench for key_ctrl; the bench plays the scanner role on scanRows/newNum.
module tb_key_ctrl;
    localparam int SS = 2;
    localparam int RC = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] colsRaw, scanRows;
    logic       newNum;
    logic [3:0] colsSync, rows, key, digit1, digit0;
    logic       scanHold, keyValid, keyErr;

    int n_cmp = 0;
    int n_bad = 0;

    key_ctrl #(.SYNC_STAGES(SS), .RELEASE_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .colsRaw(colsRaw), .scanRows(scanRows),
        .newNum(newNum), .colsSync(colsSync), .scanHold(scanHold), .rows(rows),
        .key(key), .keyValid(keyValid), .keyErr(keyErr),
        .digit1(digit1), .digit0(digit0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a press, let it cross the synchronizer, then pulse newNum.
    task automatic press(input logic [3:0] r, input logic [3:0] c);
        scanRows = r;
        colsRaw  = c;
        tick();
        chk("sync_lag", {28'd0, colsSync}, 32'd0);
        tick();
        chk("sync_out", {28'd0, colsSync}, {28'd0, c});
        newNum = 1'b1;
        tick();
        newNum   = 1'b0;
        scanRows = 4'd0;
    endtask

    // Release the key and count cycles from release-on-colsSync to SCAN.
    task automatic release_measure(input string tag);
        int n;
        colsRaw = 4'd0;
        n = 0;
        while (colsSync != 4'd0 && n < 20) begin tick(); n++; end
        chk({tag, "_relseen"}, {31'd0, (colsSync == 4'd0)}, 32'd1);
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (!scanHold) break;
        end
        chk({tag, "_holdlen"}, n, RC);
    endtask

    initial begin
        int nw;
        reset = 1'b1; colsRaw = 4'd0; scanRows = 4'd0; newNum = 1'b0;
        tick(); tick();
        chk("rst_hold", {31'd0, scanHold}, 32'd0);
        chk("rst_digits", {24'd0, digit1, digit0}, 32'h00);
        chk("rst_key", {28'd0, key}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            scanRows = 4'b0001 << (i % 4);
            tick();
            if (rows !== scanRows || scanHold || keyValid || keyErr || digit0 != 0 || digit1 != 0) begin
                chk("idle", {20'd0, rows, scanHold, keyValid, keyErr, 1'b0, digit1, digit0},
                    {20'd0, scanRows, 12'd0});
            end else n_cmp++;
        end

        // Key 6: row 1, col 2
        press(4'b0010, 4'b0100);
        chk("k6_valid", {30'd0, keyValid, keyErr}, 32'b10);
        chk("k6_key", {28'd0, key}, 32'h6);
        chk("k6_hold", {31'd0, scanHold}, 32'd1);
        chk("k6_rows_dec", {28'd0, rows}, 32'd0);
        tick();
        chk("k6_digits", {24'd0, digit1, digit0}, 32'h06);
        chk("k6_pulse_end", {31'd0, keyValid}, 32'd0);
        tick();
        chk("k6_rows_hold", {28'd0, rows}, 32'b0010);
        release_measure("k6");

        press(4'b0001, 4'b0001);
        chk("k1_key", {28'd0, key}, 32'h1);
        release_measure("k1");
        press(4'b1000, 4'b1000);
        chk("kD_key", {28'd0, key}, 32'hD);
        tick();
        chk("kD_digits", {24'd0, digit1, digit0}, 32'h1D);
        release_measure("kD");

        // Two columns at once
        press(4'b0001, 4'b0101);
        chk("err_flags", {30'd0, keyValid, keyErr}, 32'b01);
        tick();
        chk("err_pulse_end", {31'd0, keyErr}, 32'd0);
        chk("err_digits", {24'd0, digit1, digit0}, 32'h1D);
        chk("err_in_hold", {31'd0, scanHold}, 32'd1);
        release_measure("err");

        // Bounce: key 5, release ~5 cycles, re-press 1 cycle, release
        press(4'b0010, 4'b0010);
        chk("k5_key", {28'd0, key}, 32'h5);
        tick();
        colsRaw = 4'd0;
        nw = 0;
        while (colsSync != 4'd0 && nw < 20) begin tick(); nw++; end
        for (int i = 0; i < 4; i++) tick();
        colsRaw = 4'b0010;
        tick();
        colsRaw = 4'd0;
        nw = 0;
        while (colsSync == 4'd0 && nw < 20) begin tick(); nw++; end
        chk("bounce_seen", {31'd0, (colsSync != 4'd0)}, 32'd1);
        chk("bounce_still_hold", {31'd0, scanHold}, 32'd1);
        release_measure("bounce");
        chk("bounce_digits", {24'd0, digit1, digit0}, 32'hD5);

        // Reset 3 cycles into HOLD, with newNum during the pulse
        press(4'b0100, 4'b0100);
        chk("k9_key", {28'd0, key}, 32'h9);
        tick(); tick(); tick();
        chk("k9_hold", {31'd0, scanHold}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_hold", {31'd0, scanHold}, 32'd0);
        chk("arst_digits", {24'd0, digit1, digit0}, 32'h00);
        newNum = 1'b1; colsRaw = 4'd0; scanRows = 4'b0001;
        tick(); tick();
        newNum = 1'b0;
        reset  = 1'b0;
        tick();
        chk("post_rst_pulses", {30'd0, keyValid, keyErr}, 32'd0);
        chk("post_rst_hold", {31'd0, scanHold}, 32'd0);
        chk("post_rst_rows", {28'd0, rows}, 32'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
